// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
package md_pkg;

   localparam int unsigned MD_MULT_CYCLES = 5;
   localparam int unsigned MD_DIV_CYCLES  = 10;
   localparam int unsigned MD_OP_W        = 4;
   localparam int unsigned MD_DATA_W      = 32;

   typedef enum logic [MD_OP_W-1:0] {
      md_none  = 4'd0,
      md_mult  = 4'd1,
      md_multu = 4'd2,
      md_div   = 4'd3,
      md_divu  = 4'd4,
      md_mthi  = 4'd5,
      md_mtlo  = 4'd6,
      md_madd  = 4'd7,
      md_maddu = 4'd8,
      md_msub  = 4'd9,
      md_msubu = 4'd10
   } md_op_e;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_mul  = 2'd1,
      st_div  = 2'd2
   } md_state_e;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mdu_ctrl_if;
   import md_pkg::*;

   logic                 start;
   logic [MD_OP_W-1:0]   op;
   logic [MD_DATA_W-1:0] a;
   logic [MD_DATA_W-1:0] b;
   logic [MD_DATA_W-1:0] hi;
   logic [MD_DATA_W-1:0] lo;
   logic                 busy;
   logic                 done;

   modport master (output start, op, a, b, input hi, lo, busy, done);
   modport slave  (input start, op, a, b, output hi, lo, busy, done);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Optional build macro MDU_MADD_EN adds madd/maddu/msub/msubu accumulate ops.
module mdu_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic      clk,
   input  logic      reset,
   mdu_ctrl_if.slave bus
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e            state;
   md_op_e               lop;
   logic [CNT_W-1:0]     cnt;
   logic [MD_DATA_W-1:0] opa, opb, hi, lo;
   logic                 busy, done;

   logic [63:0]          prod_s, prod_u, prod;
   logic [MD_DATA_W-1:0] dvs, quo, rem;
   logic                 div_zero;

   assign bus.hi   = hi;
   assign bus.lo   = lo;
   assign bus.busy = busy;
   assign bus.done = done;

   // Arithmetic datapath works only from the operands latched at start.
   always_comb begin
      prod_s   = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
      prod_u   = {32'd0, opa} * {32'd0, opb};
      prod     = (lop == md_mult || lop == md_madd || lop == md_msub) ? prod_s : prod_u;
      div_zero = (opb == '0);
      dvs      = div_zero ? MD_DATA_W'(1) : opb;
      quo      = opa / dvs;
      rem      = opa % dvs;
      if (lop == md_div) begin
         // INT_MIN / -1 overflows; pin the architectural result explicitly.
         if (opa == 32'h8000_0000 && opb == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = '0;
         end else begin
            quo = $signed(opa) / $signed(dvs);
            rem = $signed(opa) % $signed(dvs);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= st_idle;
         lop   <= md_none;
         cnt   <= '0;
         opa   <= '0;
         opb   <= '0;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            st_idle: begin
               if (bus.start) begin
                  unique case (md_op_e'(bus.op))
                     md_mult, md_multu
`ifdef MDU_MADD_EN
                     , md_madd, md_maddu, md_msub, md_msubu
`endif
                     : begin
                        opa   <= bus.a;
                        opb   <= bus.b;
                        lop   <= md_op_e'(bus.op);
                        cnt   <= CNT_W'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= st_mul;
                     end
                     md_div, md_divu: begin
                        opa   <= bus.a;
                        opb   <= bus.b;
                        lop   <= md_op_e'(bus.op);
                        cnt   <= CNT_W'(DIV_CYCLES);
                        busy  <= 1'b1;
                        state <= st_div;
                     end
                     md_mthi: hi <= bus.a;
                     md_mtlo: lo <= bus.a;
                     default: ;
                  endcase
               end
            end
            st_mul, st_div: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               // Last busy cycle: commit HI/LO and pulse done.
               if (cnt <= CNT_W'(1)) begin
                  state <= st_idle;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (state == st_div) begin
                     if (!div_zero) begin
                        hi <= rem;
                        lo <= quo;
                     end
                  end else begin
`ifdef MDU_MADD_EN
                     if (lop == md_madd || lop == md_maddu)
                        {hi, lo} <= {hi, lo} + prod;
                     else if (lop == md_msub || lop == md_msubu)
                        {hi, lo} <= {hi, lo} - prod;
                     else
                        {hi, lo} <= prod;
`else
                     {hi, lo} <= prod;
`endif
                  end
               end
            end
            default: begin
               state <= st_idle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
